serial_adder: RTL and testbench

- Bit-serial N-bit adder; the additive counterpart to the team's full_sub subtractor cell.
- Accepts two operands and a carry-in through a valid/ready handshake.
- Adds LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop.
- Presents the sum and carry-out with a result-valid/ready handshake. Used where area matters more than latency, e.g. accumulator updates in the arithmetic datapath.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_full_add.sv | 13 +
 rtl/serial_adder.sv | 95 +++++++++
 tb/tb_serial_adder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and sizing helper for the bit-serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Counter must hold WIDTH-1 with headroom for the full range 2..32.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_full_add.sv
// rtl/serial_adder_full_add.sv - single-bit full-adder cell, sibling of full_sub
module full_add (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder, one bit per clock
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept;
  logic               shift_en;
  logic               last_bit;
  logic               fa_s;
  logic               fa_c;

  assign accept   = (state_q == ST_IDLE) && in_valid;
  assign shift_en = (state_q == ST_SHIFT);
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  full_add u_full_add (
    .x (a_q[0]),
    .y (b_q[0]),
    .z (carry_q),
    .s (fa_s),
    .c (fa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid)  state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit)  state_d = ST_HOLD;
      ST_HOLD:  if (out_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at sum_q[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      sum_q   <= '0;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (shift_en) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
      carry_q <= fa_c;
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q == ST_SHIFT);
  assign sum       = sum_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH 8 and 16
module tb_serial_adder;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [7:0]  a, b, sum;

  logic        in_valid_w, in_ready_w, cin_w, out_valid_w, out_ready_w, cout_w, busy_w;
  logic [15:0] a_w, b_w, sum_w;

  int checks   = 0;
  int failures = 0;

  logic [8:0]  exp_q[$];
  logic [16:0] exp_w_q[$];
  logic [8:0]  exp8_v;
  logic [16:0] exp16_v;
  logic        rnd_done;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_w), .in_ready(in_ready_w),
    .a(a_w), .b(b_w), .cin(cin_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w),
    .sum(sum_w), .cout(cout_w), .busy(busy_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitors: every result handshake pops one expectation, so losses and duplicates both show.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL w8_unexpected_result actual=%0h required=none", {cout, sum});
      end else begin
        exp8_v = exp_q.pop_front();
        if ({cout, sum} !== exp8_v) begin
          failures++;
          $display("FAIL w8_result actual=%0h required=%0h", {cout, sum}, exp8_v);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid_w && out_ready_w) begin
      checks++;
      if (exp_w_q.size() == 0) begin
        failures++;
        $display("FAIL w16_unexpected_result actual=%0h required=none", {cout_w, sum_w});
      end else begin
        exp16_v = exp_w_q.pop_front();
        if ({cout_w, sum_w} !== exp16_v) begin
          failures++;
          $display("FAIL w16_result actual=%0h required=%0h", {cout_w, sum_w}, exp16_v);
        end
      end
    end
  end

  task automatic send8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                       input logic [8:0] req);
    bit ok = 0;
    in_valid = 1'b1; a = ia; b = ib; cin = ic;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL w8_accept_timeout actual=in_ready_low required=accept");
    end else begin
      exp_q.push_back(req);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
  endtask

  task automatic send16(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                        input logic [16:0] req);
    bit ok = 0;
    in_valid_w = 1'b1; a_w = ia; b_w = ib; cin_w = ic;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready_w) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL w16_accept_timeout actual=in_ready_low required=accept");
    end else begin
      exp_w_q.push_back(req);
      @(posedge clk); #1;
    end
    in_valid_w = 1'b0; a_w = 16'($urandom); b_w = 16'($urandom); cin_w = 1'($urandom);
  endtask

  task automatic wait_ov8(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = busy ? 1 : 0;
    while (edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (out_valid) break;
      if (busy) busy_cycles++;
    end
    if (!out_valid) begin
      checks++; failures++;
      $display("FAIL w8_out_valid_timeout actual=0 required=1");
    end
  endtask

  int e, bc;

  initial begin
    rst_n = 1'b0; rnd_done = 1'b0;
    in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 1;
    in_valid_w = 0; a_w = 0; b_w = 0; cin_w = 0; out_ready_w = 1;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum_cout", {cout, sum}, 0);
    check("rst_w16_sum_cout", {cout_w, sum_w}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero operands: latency and busy width.
    send8(8'h00, 8'h00, 1'b0, 9'h000);
    wait_ov8(e, bc);
    check("t1_latency_edges", 1 + e, 9);
    check("t1_busy_cycles", bc, 8);
    check("t1_busy_low_in_hold", busy, 0);
    @(posedge clk); #1;

    // out_ready already high: single-cycle out_valid, in_ready back next cycle.
    send8(8'h5A, 8'h3C, 1'b0, 9'h096);
    wait_ov8(e, bc);
    check("t2_sum", sum, 8'h96);
    @(posedge clk); #1;
    check("t2_out_valid_one_cycle", out_valid, 0);
    check("t2_in_ready_back", in_ready, 1);

    send8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    wait_ov8(e, bc);
    check("t3_allones_cout_sum", {cout, sum}, 9'h1FF);
    @(posedge clk); #1;
    send8(8'hFF, 8'h01, 1'b0, 9'h100);
    wait_ov8(e, bc);
    check("t3_wrap_cout_sum", {cout, sum}, 9'h100);
    @(posedge clk); #1;

    // Backpressure with in_valid pulses during HOLD.
    out_ready = 1'b0;
    send8(8'h12, 8'h34, 1'b0, 9'h046);
    wait_ov8(e, bc);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      @(posedge clk); #1;
      check("t4_hold_sum", {cout, sum}, 9'h046);
      check("t4_hold_out_valid", out_valid, 1);
      check("t4_hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_out_valid_drop", out_valid, 0);
    check("t4_in_ready_back", in_ready, 1);
    check("t4_no_capture", busy, 0);

    // Reset three SHIFT cycles into a transaction.
    send8(8'hAA, 8'h55, 1'b0, 9'h0FF);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_in_ready", in_ready, 1);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_sum_cout", {cout, sum}, 0);
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    check("t5_no_out_valid", out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send8(8'h01, 8'h01, 1'b0, 9'h002);
    wait_ov8(e, bc);
    check("t5_after_reset_sum", {cout, sum}, 9'h002);
    @(posedge clk); #1;

    // Back-to-back traffic on both widths with random backpressure.
    fork
      begin
        fork
          for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb; logic rc;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            send8(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'b0, rc});
          end
          for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra, rb; logic rc;
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            send16(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {16'b0, rc});
          end
        join
        rnd_done = 1'b1;
      end
      while (!rnd_done) begin
        @(posedge clk); #1;
        out_ready   = 1'($urandom_range(0, 1));
        out_ready_w = 1'($urandom_range(0, 1));
      end
    join
    out_ready = 1'b1; out_ready_w = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (exp_q.size() == 0 && exp_w_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("w8_results_drained", exp_q.size(), 0);
    check("w16_results_drained", exp_w_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
